// File: rtl/digest_tx_pkg.sv
// Shared constants for the digest transmit scheduler: FSM state encodings,
// default digest width and grant index width.
package digest_tx_pkg;

    localparam int DIGEST_W_DEF = 512;
    localparam int GRANT_W      = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LAUNCH = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_ABORT  = 3'd3;
    localparam state_t ST_GAP    = 3'd4;

endpackage

// File: rtl/digest_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping at NUM_REQ. ptr must be below NUM_REQ.
module rr_arbiter
    import digest_tx_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any_req
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_req && req[j]) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/digest_tx_scheduler.sv
// Round-robin scheduler sharing one 512-to-16 converter between hash cores.
// Optional DIGEST_TX_STATS_EN adds saturating done/abort counters.
module digest_tx_scheduler
    import digest_tx_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DIGEST_W       = DIGEST_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int KILL_CYCLES    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DIGEST_W-1:0] req_digest,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [DIGEST_W-1:0]         conv_raw512,
    output logic                        conv_go,
    output logic                        conv_kill,
    input  logic                        conv_done,
    output logic                        busy,
    output logic [GRANT_W-1:0]          grant_id,
    output logic                        timeout_err,
    input  logic                        err_clr
`ifdef DIGEST_TX_STATS_EN
    ,
    output logic [15:0]                 stat_done,
    output logic [15:0]                 stat_abort
`endif
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    localparam int KILL_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

    state_t              state;
    logic [GRANT_W-1:0]  ptr;
    logic [GRANT_W-1:0]  ptr_next;
    logic [WDOG_W-1:0]   wdog;
    logic [KILL_W-1:0]   kill_cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [GRANT_W-1:0]  arb_idx;
    logic                arb_any;
    logic                wdog_expire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign ptr_next    = (arb_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : arb_idx + 3'd1;
    // conv_done in the final watchdog cycle must win over the abort
    assign wdog_expire = (state == ST_WAIT) && !conv_done &&
                         (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            wdog        <= '0;
            kill_cnt    <= '0;
            req_ack     <= '0;
            conv_raw512 <= '0;
            conv_go     <= 1'b0;
            conv_kill   <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ack <= '0;
            conv_go <= 1'b0;
            if (wdog_expire) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        conv_raw512 <= req_digest[int'(arb_idx)*DIGEST_W +: DIGEST_W];
                        grant_id    <= arb_idx;
                        ptr         <= ptr_next;
                        req_ack     <= arb_grant;
                        conv_go     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (conv_done) begin
                        state <= ST_GAP;
                    end else if (wdog_expire) begin
                        conv_kill <= 1'b1;
                        kill_cnt  <= '0;
                        state     <= ST_ABORT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (kill_cnt == KILL_W'(KILL_CYCLES - 1)) begin
                        conv_kill <= 1'b0;
                        state     <= ST_GAP;
                    end else begin
                        kill_cnt <= kill_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    conv_kill <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DIGEST_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_done  <= '0;
            stat_abort <= '0;
        end else begin
            if (state == ST_WAIT && conv_done && stat_done != 16'hFFFF) begin
                stat_done <= stat_done + 16'd1;
            end
            if (wdog_expire && stat_abort != 16'hFFFF) begin
                stat_abort <= stat_abort + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_digest_tx_scheduler.sv
// Scoreboard bench for digest_tx_scheduler: expected grants are queued at
// stimulus time and popped by a monitor whenever conv_go pulses.
module tb_digest_tx_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DW      = 512;
    localparam int TO      = 64;
    localparam int KC      = 2;

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*DW-1:0]  req_digest;
    logic [NUM_REQ-1:0]     req_ack;
    logic [DW-1:0]          conv_raw512;
    logic                   conv_go;
    logic                   conv_kill;
    logic                   conv_done;
    logic                   busy;
    logic [2:0]             grant_id;
    logic                   timeout_err;
    logic                   err_clr;
`ifdef DIGEST_TX_STATS_EN
    logic [15:0]            stat_done;
    logic [15:0]            stat_abort;
`endif

    digest_tx_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .DIGEST_W       (DW),
        .TIMEOUT_CYCLES (TO),
        .KILL_CYCLES    (KC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_digest  (req_digest),
        .req_ack     (req_ack),
        .conv_raw512 (conv_raw512),
        .conv_go     (conv_go),
        .conv_kill   (conv_kill),
        .conv_done   (conv_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
`ifdef DIGEST_TX_STATS_EN
        ,
        .stat_done   (stat_done),
        .stat_abort  (stat_abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    gid;
        logic [DW-1:0] dig;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DW-1:0] dig_a5;
    logic [DW-1:0] dig_3c;
    logic [DW-1:0] dig_de;
    logic [DW-1:0] dig_77;
    logic [DW-1:0] dig_12;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    exp_t          mon_e;
    logic [1:0]    mon_oh;
    int            kill_len = 0;

    // Monitor: every conv_go must match the next queued grant
    always @(negedge clk) begin
        if (conv_go) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_go: grant_id %0d with empty queue", grant_id);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_oh = 2'b01 << mon_e.gid;
                check_output("grant_id", DW'(grant_id), DW'(mon_e.gid));
                check_output("req_ack_with_go", DW'(req_ack), DW'(mon_oh));
                check_output("conv_raw512", conv_raw512, mon_e.dig);
            end
        end else if (req_ack != '0) begin
            check_output("req_ack_without_go", DW'(req_ack), '0);
        end
        if (conv_kill) begin
            kill_len++;
        end else if (kill_len != 0) begin
            check_output("kill_len", DW'(kill_len), DW'(KC));
            kill_len = 0;
        end
    end

    task automatic apply_stimulus(input int idx, input logic [DW-1:0] dig);
        exp_t e;
        req_digest[idx*DW +: DW] = dig;
        req_valid[idx]           = 1'b1;
        e.gid = 3'(idx);
        e.dig = dig;
        exp_q.push_back(e);
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] dig);
        exp_t e;
        e.gid = 3'(idx);
        e.dig = dig;
        exp_q.push_back(e);
    endtask

    task automatic wait_go(output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (conv_go) begin
                ok     = 1'b1;
                cycles = i;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL wait_go: no conv_go within 30 cycles");
        end
    endtask

    // drop: 0 keep valids, 1 drop acked requester, 2 drop all
    task automatic serve(input int delay, input int drop);
        bit ok;
        int cyc;
        wait_go(ok, cyc);
        if (!ok) return;
        if (drop == 1) req_valid = req_valid & ~req_ack;
        else if (drop == 2) req_valid = '0;
        repeat (delay) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req_ack"}, DW'(req_ack), '0);
        check_output({tag, "_conv_go"}, DW'(conv_go), '0);
        check_output({tag, "_conv_kill"}, DW'(conv_kill), '0);
        check_output({tag, "_busy"}, DW'(busy), '0);
        check_output({tag, "_grant_id"}, DW'(grant_id), '0);
        check_output({tag, "_timeout_err"}, DW'(timeout_err), '0);
        check_output({tag, "_conv_raw512"}, conv_raw512, '0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_digest = '0;
        conv_done  = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic run_timeout(input bit clr_on_expiry);
        bit ok;
        int cyc;
        int lat;
        wait_go(ok, cyc);
        if (!ok) return;
        req_valid = '0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (clr_on_expiry && i == TO) err_clr = 1'b1;
            if (conv_kill) begin
                lat = i;
                break;
            end
        end
        err_clr = 1'b0;
        check_output("abort_latency", DW'(lat), DW'(TO + 1));
        check_output("timeout_err_set", DW'(timeout_err), DW'(1));
        repeat (3) @(negedge clk);
        check_output("busy_after_abort", DW'(busy), '0);
    endtask

    initial begin
        bit ok;
        int cyc;
        dig_a5 = {64{8'hA5}};
        dig_3c = {16{32'h3C3C_0F0F}};
        dig_de = {16{32'hDEAD_BEEF}};
        dig_77 = {16{32'h7777_1234}};
        dig_12 = {16{32'h1234_5678}};

        // Test 1: single capture, 1-cycle valid-to-go latency
        do_reset();
        apply_stimulus(0, dig_a5);
        wait_go(ok, cyc);
        check_output("valid_to_go", DW'(cyc), DW'(1));
        req_valid = '0;
        repeat (35) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        check_output("busy_in_gap", DW'(busy), DW'(1));
        @(negedge clk);
        check_output("busy_idle", DW'(busy), '0);
        check_output("raw512_stable", conv_raw512, dig_a5);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        @(negedge clk);
        check_output("done_in_idle_ignored", DW'(busy), '0);

        // Test 2: alternation between two continuously valid requesters
        do_reset();
        apply_stimulus(0, dig_a5);
        apply_stimulus(1, dig_3c);
        push_exp(0, dig_a5);
        push_exp(1, dig_3c);
        serve(35, 0);
        serve(35, 0);
        serve(35, 0);
        serve(35, 2);
        @(negedge clk);

        // Test 3: watchdog abort; err_clr in the expiry cycle loses to set
        apply_stimulus(0, dig_de);
        run_timeout(1'b1);
        check_output("timeout_err_sticky", DW'(timeout_err), DW'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("timeout_err_cleared", DW'(timeout_err), '0);

        // Test 4: done on the final watchdog cycle; transient req1 ignored
        apply_stimulus(0, dig_77);
        wait_go(ok, cyc);
        req_valid = '0;
        repeat (3) @(negedge clk);
        req_valid[1] = 1'b1;
        repeat (2) @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (TO - 5) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        check_output("late_done_no_kill", DW'(conv_kill), '0);
        check_output("late_done_no_err", DW'(timeout_err), '0);
        check_output("late_done_busy_gap", DW'(busy), DW'(1));
        repeat (3) @(negedge clk);
        check_output("late_done_idle", DW'(busy), '0);

        // Test 5: reset during WAIT, then requester 0 wins
        apply_stimulus(1, dig_3c);
        wait_go(ok, cyc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        apply_stimulus(0, dig_a5);
        apply_stimulus(1, dig_3c);
        reset = 1'b0;
        serve(35, 1);
        serve(35, 1);
        @(negedge clk);

        // Test 6: third completion then a timeout
        apply_stimulus(0, dig_12);
        serve(35, 1);
        @(negedge clk);
        apply_stimulus(1, dig_de);
        run_timeout(1'b0);
`ifdef DIGEST_TX_STATS_EN
        check_output("stat_done", DW'(stat_done), DW'(3));
        check_output("stat_abort", DW'(stat_abort), DW'(1));
`endif
        repeat (2) @(negedge clk);
        check_output("queue_drained", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
